// File: rtl/writeback_unit.sv
// Write-back stage: buffers ALU/load results in a small in-order FIFO and
// drains them into the register file as single-cycle WriteEnable pulses
// separated by at least one low cycle. Also flags read-after-write hazards
// for results that are still queued.
//
// state | meaning
// IDLE  | no write in flight; pop head when FIFO non-empty
// DRIVE | WriteEnable high for this one cycle
// GAP   | WriteEnable low, address/data held; may start the next pulse
module writeback_unit #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDR_W-1:0]        alu_addr,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_data,
   input  logic                     flush,
   input  logic [ADDR_W-1:0]        readAddr1,
   input  logic [ADDR_W-1:0]        readAddr2,
   output logic                     hazard1,
   output logic                     hazard2,
   output logic [ADDR_W-1:0]        writeAddr,
   output logic [DATA_W-1:0]        writedata,
   output logic                     WriteEnable,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_q [DEPTH];
   logic [DATA_W-1:0]   data_q [DEPTH];
   logic [PTR_W-1:0]    wptr, rptr;
   logic                full, empty, push, pop;
   logic [ADDR_W-1:0]   push_addr;
   logic [DATA_W-1:0]   push_data;
   logic [IDX_W-1:0]    head;

   assign count     = wptr - rptr;
   assign empty     = (wptr == rptr);
   assign full      = (count == PTR_W'(DEPTH));
   assign head      = rptr[IDX_W-1:0];

   // Load channel has fixed priority; no bypass when full even if popping.
   assign mem_ready = !full;
   assign alu_ready = !full && !mem_valid;
   assign push      = !flush && ((mem_valid && mem_ready) || (alu_valid && alu_ready));
   assign push_addr = mem_valid ? mem_addr : alu_addr;
   assign push_data = mem_valid ? mem_data : alu_data;
   assign busy      = !empty || (state != IDLE);

   // FIFO pointers; flush empties the queue and drops a same-cycle push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // FIFO storage; contents are only meaningful between rptr and wptr
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wptr[IDX_W-1:0]] <= push_addr;
         data_q[wptr[IDX_W-1:0]] <= push_data;
      end
   end

   // Issue FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Issue FSM next state and pop decision; flush suppresses a new pulse
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !flush) begin
               pop       = 1'b1;
               state_nxt = DRIVE;
            end
         end
         DRIVE: state_nxt = GAP;
         GAP: begin
            if (!empty && !flush) begin
               pop       = 1'b1;
               state_nxt = DRIVE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered register-file write port; address/data hold between pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WriteEnable <= 1'b0;
         writeAddr   <= '0;
         writedata   <= '0;
      end else begin
         WriteEnable <= pop;
         if (pop) begin
            writeAddr <= addr_q[head];
            writedata <= data_q[head];
         end
      end
   end

   // Hazards cover queued entries only; the driven entry has already left the FIFO
   always_comb begin
      logic [IDX_W-1:0] idx;
      hazard1 = 1'b0;
      hazard2 = 1'b0;
      idx     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + IDX_W'(i);
         if (PTR_W'(i) < count) begin
            if (addr_q[idx] == readAddr1) hazard1 = 1'b1;
            if (addr_q[idx] == readAddr2) hazard2 = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: a queue-based reference model predicts acceptance,
// occupancy, hazards and issued writes; a negedge monitor checks the DUT.
module tb_writeback_unit;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              alu_valid = 1'b0, mem_valid = 1'b0, flush = 1'b0;
   logic [ADDR_W-1:0] alu_addr = '0, mem_addr = '0, readAddr1 = '0, readAddr2 = '0;
   logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
   logic              alu_ready, mem_ready, hazard1, hazard2, WriteEnable, busy;
   logic [ADDR_W-1:0] writeAddr;
   logic [DATA_W-1:0] writedata;
   logic [CNT_W-1:0]  count;

   writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .flush(flush), .readAddr1(readAddr1), .readAddr2(readAddr2),
      .hazard1(hazard1), .hazard2(hazard2),
      .writeAddr(writeAddr), .writedata(writedata), .WriteEnable(WriteEnable),
      .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;

   int   total = 0;
   int   bad   = 0;
   ent_t q[$];
   ent_t sb[$];
   bit   mdl_we = 0, mdl_we_d1 = 0, we_prev = 0;
   logic [ADDR_W-1:0] mdl_addr = '0;
   logic [DATA_W-1:0] mdl_data = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: queued results, writes spaced so no two pulses are adjacent
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         sb.delete();
         mdl_we    = 0;
         mdl_we_d1 = 0;
         mdl_addr  = '0;
         mdl_data  = '0;
      end else begin
         bit   full, pop, push;
         ent_t e, h;
         full = (q.size() == DEPTH);
         pop  = (q.size() > 0) && !flush && !mdl_we;
         push = !flush && !full && (mem_valid || alu_valid);
         e    = mem_valid ? {mem_addr, mem_data} : {alu_addr, alu_data};
         mdl_we_d1 = mdl_we;
         if (flush) q.delete();
         if (pop) begin
            h = q.pop_front();
            sb.push_back(h);
            mdl_addr = h.a;
            mdl_data = h.d;
         end
         mdl_we = pop;
         if (push) q.push_back(e);
      end
   end

   // Monitor: compare combinational/registered outputs, pop scoreboard on each pulse
   always @(negedge clk) begin
      bit   hz1, hz2;
      ent_t e;
      hz1 = 0;
      hz2 = 0;
      foreach (q[i]) begin
         if (q[i].a == readAddr1) hz1 = 1;
         if (q[i].a == readAddr2) hz2 = 1;
      end
      chk("count", 32'(count), q.size());
      chk("mem_ready", mem_ready, q.size() < DEPTH);
      chk("alu_ready", alu_ready, (q.size() < DEPTH) && !mem_valid);
      chk("hazard1", hazard1, hz1);
      chk("hazard2", hazard2, hz2);
      chk("busy", busy, (q.size() > 0) || mdl_we || mdl_we_d1);
      chk("write_enable", WriteEnable, mdl_we);
      chk("write_addr_hold", writeAddr, mdl_addr);
      chk("write_data_hold", writedata, mdl_data);
      chk("we_back_to_back", WriteEnable && we_prev, 0);
      if (WriteEnable) begin
         chk("sb_expected_write", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_addr", writeAddr, e.a);
            chk("sb_data", writedata, e.d);
         end
      end
      we_prev = WriteEnable;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 0;
      mem_valid = 0;
      flush     = 0;
   endtask

   initial begin
      bit acc;
      int i, guard;

      // reset state, ready/hazard visible while in reset
      #1;
      chk("rst_we", WriteEnable, 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_waddr", writeAddr, 0);
      chk("rst_wdata", writedata, 0);
      chk("rst_alu_ready", alu_ready, 1);
      chk("rst_mem_ready", mem_ready, 1);
      chk("rst_hazard1", hazard1, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1;
      tick(2);

      // single ALU result
      alu_valid = 1; alu_addr = 4'd3; alu_data = 16'h1234;
      tick();
      idle_inputs();
      tick(6);

      // load priority and ordering
      mem_valid = 1; mem_addr = 4'd5; mem_data = 16'hAAAA;
      alu_valid = 1; alu_addr = 4'd6; alu_data = 16'hBBBB;
      tick();
      mem_valid = 0;
      tick();
      idle_inputs();
      tick(8);

      // fill to full; hold each offer until it is taken
      i = 0; guard = 0;
      alu_valid = 1; alu_addr = 4'd0; alu_data = 16'h5000;
      while (i < 8 && guard < 60) begin
         acc = alu_ready;
         tick();
         guard++;
         if (acc) begin
            i++;
            alu_addr = 4'(i);
            alu_data = 16'h5000 + 16'(i);
         end
      end
      chk("fill_timeout", guard < 60, 1);
      idle_inputs();
      tick(20);

      // hazard on a queued r7
      readAddr1 = 4'd7; readAddr2 = 4'd2;
      alu_valid = 1; alu_addr = 4'd1; alu_data = 16'h0101;
      tick();
      alu_addr = 4'd7; alu_data = 16'h0707;
      tick();
      idle_inputs();
      tick(8);

      // flush during a DRIVE cycle with a same-cycle push
      for (int k = 0; k < 4; k++) begin
         alu_valid = 1; alu_addr = 4'(8 + k); alu_data = 16'hF000 + 16'(k);
         tick();
      end
      alu_addr = 4'd12; alu_data = 16'hFFFF; flush = 1;
      tick();
      idle_inputs();
      tick(8);

      // asynchronous reset mid-pulse
      alu_valid = 1; alu_addr = 4'd9; alu_data = 16'h9999;
      tick();
      alu_valid = 1; alu_addr = 4'd10; alu_data = 16'hA0A0;
      tick();
      idle_inputs();
      @(negedge clk); #2;
      rst_n = 0;
      #1;
      chk("async_we", WriteEnable, 0);
      chk("async_waddr", writeAddr, 0);
      chk("async_wdata", writedata, 0);
      chk("async_count", 32'(count), 0);
      @(posedge clk); #1;
      rst_n = 1;
      tick(2);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         mem_valid = ($urandom_range(0, 3) == 0);
         alu_valid = ($urandom_range(0, 1) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         mem_addr  = 4'($urandom); mem_data = 16'($urandom);
         alu_addr  = 4'($urandom); alu_data = 16'($urandom);
         readAddr1 = 4'($urandom); readAddr2 = 4'($urandom);
         tick();
      end
      idle_inputs();
      tick(20);
      chk("drain_scoreboard", sb.size(), 0);
      chk("drain_queue", 32'(count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
